// File: rtl/fetch_unit.sv
// Instruction fetch FSM: one request per instruction, one bubble per handoff, redirect on branch/jump.
// Latency: instr valid the cycle after imem_ack. Backpressure: a word sits in HOLD until instr_ready.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redir_valid,
  input  logic        B,
  input  logic        J,
  input  logic        cond,
  input  logic [15:0] imm16,
  input  logic [25:0] jtarget,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {FETCH, HOLD, DISCARD} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt, hold_addr, addr_sel;
  logic [31:0] seq_pc, br_target, j_target, target;
  logic        take, load_instr, handoff;

  assign seq_pc    = instr_pc + 32'd4;
  assign br_target = seq_pc + {{14{imm16[15]}}, imm16, 2'b00};
  assign j_target  = {seq_pc[31:28], jtarget, 2'b00};
  assign target    = J ? j_target : br_target;
  assign take      = redir_valid && (J || (B && cond));

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    load_instr = 1'b0;
    handoff    = 1'b0;
    case (state)
      FETCH: begin
        if (take) begin
          // An un-acked request cannot be withdrawn, so its data must be swallowed later.
          pc_nxt    = target;
          state_nxt = imem_ack ? FETCH : DISCARD;
        end else if (imem_ack) begin
          load_instr = 1'b1;
          pc_nxt     = pc + 32'd4;
          state_nxt  = HOLD;
        end
      end
      HOLD: begin
        handoff = instr_ready;
        if (take) begin
          pc_nxt    = target;
          state_nxt = FETCH;
        end else if (instr_ready) begin
          state_nxt = FETCH;
        end
      end
      DISCARD: begin
        if (take) pc_nxt = target;
        if (imem_ack) state_nxt = FETCH;
      end
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      hold_addr   <= RESET_PC;
      instr       <= 32'd0;
      instr_pc    <= 32'd0;
      fetch_count <= 32'd0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      // Remembers the address of the request still in flight while pc moves on.
      if (state == FETCH) hold_addr <= pc;
      if (load_instr) begin
        instr    <= imem_rdata;
        instr_pc <= pc;
      end
      if (handoff) fetch_count <= fetch_count + 32'd1;
    end
  end

  assign addr_sel    = (state == DISCARD) ? hold_addr : pc;
  assign imem_addr   = addr_sel & 32'hFFFF_FFFC;
  assign imem_req    = (state != HOLD);
  assign instr_valid = (state == HOLD);
  assign op          = instr[31:26];

endmodule
